vga_timing_core: RTL and testbench
==================================

// Module: vga_timing_core
// PURPOSE
//  Parametrised VGA raster engine, successor to the fixed-timing controller.
//  Generates hsync/vsync/de and pixel coordinates from programmable timing.
//  Adds configurable sync polarity, a PIPE_LAT-cycle pixel-source alignment
//  pipe, an enable, and built-in test patterns selected per frame.
//  Sits between the pixel PLL clock domain and the pixel RAM / DAC pins.
// PARAMETERS
//  H_ACTIVE 683  visible pixels per line
//  H_FP     32   horizontal front porch, pixels
//  H_SYNC   56   hsync width, pixels
//  H_BP     125  horizontal back porch, pixels (H_TOTAL = 896)
//  V_ACTIVE 768  visible lines per frame
//  V_FP     3    vertical front porch, lines
//  V_SYNC   6    vsync width, lines
//  V_BP     18   vertical back porch, lines (V_TOTAL = 795)
//  H_POL    0    hsync active level (0 = active-low)
//  V_POL    0    vsync active level (0 = active-low)
//  COLOR_W  1    bits per colour channel
//  PIPE_LAT 1    pixel source read latency in clocks (0..8)
//  CHK_LOG2 4    checker cell size = 2**CHK_LOG2 pixels
// PORTS
//  clk         in  1          pixel clock
//  areset      in  1          async reset, active-high
//  enable      in  1          1 = run raster, 0 = hold at origin, blank
//  mode        in  2          0 ext pixel, 1 colour bars, 2 checker, 3 solid
//  solid_rgb   in  3*COLOR_W  {R,G,B} for mode 3
//  pix_data    in  3*COLOR_W  {R,G,B} from pixel source, PIPE_LAT after pix_req
//  pix_req     out 1          coordinate valid (active area), combinational
//  pix_x       out clog2(H_TOTAL) current h counter
//  pix_y       out clog2(V_TOTAL) current v counter
//  h_sync      out 1          horizontal sync, polarity H_POL
//  v_sync      out 1          vertical sync, polarity V_POL
//  de          out 1          data enable, aligned to r/g/b
//  r,g,b       out COLOR_W    colour outputs, 0 when de=0
//  frame_start out 1          1-cycle pulse with first active pixel of frame
// BEHAVIOUR
//  - Reset: h/v counters 0, mode register 0, pipe flushed; h_sync=~H_POL,
//    v_sync=~V_POL, de=0, r/g/b=0, frame_start=0.
//  - h_cnt 0..H_TOTAL-1, wraps to 0 and increments v_cnt; v_cnt wraps at
//    V_TOTAL-1 on the h wrap. Line order: active, FP, sync, BP.
//  - hsync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC;
//    vsync same rule on v_cnt; vsync changes on line boundary (h_cnt=0).
//  - pix_req = enable & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE; pix_x/pix_y = counters.
//  - Stage-0 signals (sync, active, pattern) are delayed PIPE_LAT cycles, then
//    registered: outputs lag the counters by exactly PIPE_LAT+1 clocks, and
//    pix_data sampled for mode 0 corresponds to the same coordinate.
//  - mode is sampled into mode register only when h_cnt=0 & v_cnt=0 & enable;
//    mid-frame mode changes take effect next frame. No tearing.
//  - Colour bars: idx = min(x/(H_ACTIVE/8),7) computed with parameter compare
//    thresholds (no divider); R=~idx[1], G=~idx[2], B=~idx[0], each bit
//    replicated to COLOR_W (white,yellow,cyan,green,magenta,red,blue,black).
//  - Checker: white when x[CHK_LOG2]^y[CHK_LOG2] = 0, else black.
//  - Solid: solid_rgb, sampled at stage 0.
//  - enable=0: counters forced to 0 synchronously and held; stage-0 active and
//    sync inputs forced inactive so outputs go blank/inactive PIPE_LAT+1 later.
//    enable rising: counting resumes from 0,0 next clock; mode sampled then.
//  - frame_start: stage-0 term (h=0,v=0,enable) through same pipe.
//  - areset mid-frame: immediate return to reset values, pipe cleared.
// TESTING
//  - Reset: hold areset 5 clks -> h_sync=1,v_sync=1,de=0,rgb=0; release,
//    counters reach 895 then 0, v_cnt increments to 1.
//  - Timing, defaults: h_sync low for exactly 56 clks starting 715+PIPE_LAT+1
//    clks after line start; v_sync low 6 lines; 896x795 clocks per frame.
//  - Mode 1, COLOR_W=1: de pixels 0..84 = 111, 85..169 = 110, 595..682 = 000.
//  - Mode 0, PIPE_LAT=3, source returns {x[2:0]} 3 clks after pix_req ->
//    rgb at de pixel n equals n[2:0] for all n; first de aligned to frame_start.
//  - Mode switch 1->2 at v_cnt=100: bars continue until frame end, checker
//    from next frame_start (pixel 16 of line 0 black, pixel 0 white).
//  - enable drop at h=300,v=50: outputs blank after PIPE_LAT+1; re-enable ->
//    frame_start after PIPE_LAT+1, sync polarity H_POL=1 variant mirrors.

Source files
------------

// File: rtl/vga_timing_core_if.sv
// rtl/vga_timing_core_if.sv - pixel-source request/data and video output bundle of the raster engine
interface vga_timing_core_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int COLOR_W = 1
);
  logic                 pix_req;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic [3*COLOR_W-1:0] pix_data;
  logic                 h_sync;
  logic                 v_sync;
  logic                 de;
  logic [COLOR_W-1:0]   r;
  logic [COLOR_W-1:0]   g;
  logic [COLOR_W-1:0]   b;
  logic                 frame_start;

  modport master (
    output pix_req, pix_x, pix_y, h_sync, v_sync, de, r, g, b, frame_start,
    input  pix_data
  );

  modport slave (
    input  pix_req, pix_x, pix_y, h_sync, v_sync, de, r, g, b, frame_start,
    output pix_data
  );
endinterface

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - programmable VGA raster engine with aligned pixel-source pipe and test patterns
module vga_timing_core #(
  parameter int H_ACTIVE = 683,
  parameter int H_FP     = 32,
  parameter int H_SYNC   = 56,
  parameter int H_BP     = 125,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 18,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int COLOR_W  = 1,
  parameter int PIPE_LAT = 1,
  parameter int CHK_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  vga_timing_core_if.master    vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int CW      = 3 * COLOR_W;
  localparam int BAR_W   = H_ACTIVE / 8;
  // stage-0 word: {frame_start, hsync_on, vsync_on, active, ext_src, pattern}
  localparam int SW      = CW + 5;

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic [1:0]    mode_q;
  logic [1:0]    mode_eff;
  logic          h_last;
  logic          v_last;
  logic          origin;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic [2:0]    bar_idx;
  logic          chk_white;
  logic [CW-1:0] pattern;
  logic [SW-1:0] s0;
  logic [SW-1:0] s_d;

  assign h_last = (h_cnt == XW'(H_TOTAL - 1));
  assign v_last = (v_cnt == YW'(V_TOTAL - 1));
  assign origin = enable && (h_cnt == '0) && (v_cnt == '0);
  assign active = enable && (h_cnt < XW'(H_ACTIVE)) && (v_cnt < YW'(V_ACTIVE));
  assign hs_on  = enable && (h_cnt >= XW'(H_ACTIVE + H_FP)) &&
                  (h_cnt < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on  = enable && (v_cnt >= YW'(V_ACTIVE + V_FP)) &&
                  (v_cnt < YW'(V_ACTIVE + V_FP + V_SYNC));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mode_q <= 2'd0;
    end else if (origin) begin
      mode_q <= mode;
    end
  end

  // The first pixel of a frame already uses the newly sampled mode, so no
  // frame ever mixes two patterns.
  always_comb begin
    mode_eff = origin ? mode : mode_q;
    bar_idx  = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= XW'(i * BAR_W)) bar_idx = 3'(i);
    end
    chk_white = ~(h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]);
    case (mode_eff)
      2'd1:    pattern = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[0]}}};
      2'd2:    pattern = {CW{chk_white}};
      2'd3:    pattern = solid_rgb;
      default: pattern = '0;
    endcase
    s0 = {origin, hs_on, vs_on, active, (mode_eff == 2'd0), pattern};
  end

  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign s_d = s0;
    end else begin : g_pipe
      logic [SW-1:0] pipe [PIPE_LAT];
      always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
          for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= s0;
          for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign s_d = pipe[PIPE_LAT-1];
    end
  endgenerate

  logic          hs_q;
  logic          vs_q;
  logic          de_q;
  logic          fs_q;
  logic [CW-1:0] rgb_q;

  // pix_data arriving now belongs to the coordinate leaving the pipe now.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= s_d[CW+3] ? H_POL : ~H_POL;
      vs_q  <= s_d[CW+2] ? V_POL : ~V_POL;
      de_q  <= s_d[CW+1];
      fs_q  <= s_d[CW+4];
      rgb_q <= !s_d[CW+1] ? '0 : (s_d[CW] ? vid.pix_data : s_d[CW-1:0]);
    end
  end

  assign vid.pix_req     = active;
  assign vid.pix_x       = h_cnt;
  assign vid.pix_y       = v_cnt;
  assign vid.h_sync      = hs_q;
  assign vid.v_sync      = vs_q;
  assign vid.de          = de_q;
  assign vid.frame_start = fs_q;
  assign vid.r           = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vid.g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vid.b           = rgb_q[COLOR_W-1:0];
endmodule

// File: tb/tb_vga_timing_core.sv
// tb/tb_vga_timing_core.sv - randomized bench for vga_timing_core against a cycle-indexed raster model
module tb_vga_timing_core;
  localparam int HA = 43, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 20, VF = 2, VS = 3, VB = 3, VT = VA + VF + VS + VB;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int CWD = 2, L = 3, CHK = 2, NCYC = 12000;
  localparam int XW = $clog2(HT), YW = $clog2(VT);
  localparam logic [9:0] BLANK = {1'b0, ~HP, ~VP, 1'b0, 6'b0};

  logic       clk = 1'b0;
  logic       areset;
  logic       enable;
  logic [1:0] mode;
  logic [5:0] solid;

  vga_timing_core_if #(.XW(XW), .YW(YW), .COLOR_W(CWD)) vid ();

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .COLOR_W(CWD), .PIPE_LAT(L), .CHK_LOG2(CHK)
  ) dut (
    .clk(clk), .areset(areset), .enable(enable), .mode(mode),
    .solid_rgb(solid), .vid(vid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [5:0] src_fn(input int x, input int y);
    return 6'((x * 5) ^ (y * 9) ^ (x >> 3));
  endfunction

  // Expected video word {frame_start, h_sync, v_sync, de, rgb} for a raster position.
  function automatic logic [9:0] expect_px(input bit en, input int x, input int y,
                                           input logic [1:0] md, input logic [5:0] sld);
    bit         act, hs, vs, fs;
    int         idx;
    logic [5:0] rgb;
    act = en && x < HA && y < VA;
    hs  = en && x >= HA + HF && x < HA + HF + HS;
    vs  = en && y >= VA + VF && y < VA + VF + VS;
    fs  = en && x == 0 && y == 0;
    rgb = 6'b0;
    if (act) begin
      case (md)
        2'd0: rgb = src_fn(x, y);
        2'd1: begin
          idx = x / (HA / 8);
          if (idx > 7) idx = 7;
          rgb = {((idx & 2) != 0) ? 2'b00 : 2'b11,
                 ((idx & 4) != 0) ? 2'b00 : 2'b11,
                 ((idx & 1) != 0) ? 2'b00 : 2'b11};
        end
        2'd2: rgb = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 6'h00 : 6'h3f;
        default: rgb = sld;
      endcase
    end
    return {fs, hs ? HP : ~HP, vs ? VP : ~VP, act, rgb};
  endfunction

  int         k, mx, my, mseq, dis_left;
  bit         act, at_org;
  logic [1:0] mreg, md;
  logic [5:0] srcq[$];
  logic [9:0] expq[$];
  logic [9:0] obs;

  initial begin
    areset = 1'b1; enable = 1'b0; mode = 2'd1; solid = 6'h2d;
    vid.pix_data = 6'h00;
    k = 0; mseq = 1; dis_left = 0; mreg = 2'd0;
    for (int i = 0; i <= L; i++) expq.push_back(BLANK);

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      @(negedge clk);
      areset = (c < 5) || (c >= 9000 && c < 9003);
      if (c == 6) enable = 1'b1;
      if (dis_left > 0) begin
        dis_left--;
        if (dis_left == 0) enable = 1'b1;
      end else if (c > 6 && (c == 3000 || $urandom_range(0, 2499) == 0)) begin
        enable   = 1'b0;
        dis_left = $urandom_range(1, 80);
      end
      if ($urandom_range(0, 899) == 0) begin
        mseq = (mseq + 1) % 4;
        mode = 2'(mseq);
      end
      if ($urandom_range(0, 49) == 0) solid = 6'($urandom);
      #1;

      // Pixel source: answers each request L cycles later, garbage otherwise.
      srcq.push_back(vid.pix_req ? src_fn(int'(vid.pix_x), int'(vid.pix_y)) : 6'($urandom));
      if (srcq.size() > L) vid.pix_data = srcq.pop_front();

      if (areset) begin
        k    = 0;
        mreg = 2'd0;
      end
      mx  = k % HT;
      my  = (k / HT) % VT;
      act = enable && mx < HA && my < VA;
      chk_eq("coord", {51'b0, vid.pix_req, vid.pix_x, vid.pix_y}, {51'b0, act, XW'(mx), YW'(my)});

      obs = {vid.frame_start, vid.h_sync, vid.v_sync, vid.de, vid.r, vid.g, vid.b};
      if (areset) begin
        chk_eq("reset_out", {54'b0, obs}, {54'b0, BLANK});
        expq.delete();
        for (int i = 0; i <= L; i++) expq.push_back(BLANK);
      end else begin
        chk_eq("video", {54'b0, obs}, {54'b0, expq.pop_front()});
        at_org = enable && mx == 0 && my == 0;
        md     = at_org ? mode : mreg;
        if (at_org) mreg = mode;
        expq.push_back(expect_px(enable, mx, my, md, solid));
        k = enable ? k + 1 : 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
